// File: rtl/mem_access_pkg.sv
// Shared definitions for the misaligned access unit: FSM states, the
// load/store size encodings and a helper mapping an encoding to a byte count.
package mem_access_pkg;

    localparam int WORD_BYTES = 4;

    // Load/store size encodings; these must track the values in controls.sv.
    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LD_HI,
        ST_WR_LO,
        ST_RD_HI,
        ST_WR_HI,
        DONE
    } mau_state_t;

    // Number of bytes moved by an access of the given type.
    function automatic logic [2:0] ls_size(input logic [1:0] ls_type);
        case (ls_type)
            LS_HALF: return 3'd2;
            LS_WORD: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering for split accesses (purely combinational).
// Store side: merges the store bytes that land in one word (low or high
// phase) into a previously read copy of that word.
// Load side: extracts size bytes little-endian from {hi,lo} starting at the
// byte offset and sign- or zero-extends them to 32 bits.
module lane_align (
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic        i_phase_hi,
    input  logic [31:0] i_base,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic        i_unsigned,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [5:0]  w_shamt;
    logic [63:0] w_mask;
    logic [63:0] w_mask_sh;
    logic [63:0] w_wdata_sh;
    logic [31:0] w_load_sh;
    logic        w_sign;

    assign w_shamt    = {1'b0, i_off, 3'b000};
    assign w_wdata_sh = {32'b0, i_wdata} << w_shamt;
    assign w_mask_sh  = w_mask << w_shamt;
    assign w_load_sh  = 32'({i_hi, i_lo} >> w_shamt);

    // Byte-enable mask for the access size, before shifting to the offset.
    always_comb begin
        case (i_size)
            3'd4:    w_mask = 64'h0000_0000_FFFF_FFFF;
            3'd2:    w_mask = 64'h0000_0000_0000_FFFF;
            default: w_mask = 64'h0000_0000_0000_00FF;
        endcase
    end

    // Store merge: the low phase covers lanes off..3, the high phase the spill-over lanes.
    always_comb begin
        o_merged = i_base;
        if (i_phase_hi) begin
            o_merged = (i_base & ~w_mask_sh[63:32]) | (w_wdata_sh[63:32] & w_mask_sh[63:32]);
        end else begin
            o_merged = (i_base & ~w_mask_sh[31:0]) | (w_wdata_sh[31:0] & w_mask_sh[31:0]);
        end
    end

    // Load extract with sign/zero extension from the top byte of the access.
    always_comb begin
        o_load = w_load_sh;
        w_sign = 1'b0;
        case (i_size)
            3'd4: o_load = w_load_sh;
            3'd2: begin
                w_sign = ~i_unsigned & w_load_sh[15];
                o_load = {{16{w_sign}}, w_load_sh[15:0]};
            end
            default: begin
                w_sign = ~i_unsigned & w_load_sh[7];
                o_load = {{24{w_sign}}, w_load_sh[7:0]};
            end
        endcase
    end

endmodule

// File: rtl/misaligned_access_unit.sv
// Misaligned access unit: sits between the core load/store path and
// data_memory. Aligned and byte accesses pass straight through; misaligned
// halfword/word accesses are split into aligned word reads and
// read-modify-write sequences while stalling the core.
// Build option: define MISALIGNED_TRAP_EN to reject misaligned requests with
// misaligned_err instead of splitting them.
module misaligned_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_ls_type,
    input  logic                  req_unsigned,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  stall,
    output logic                  misaligned_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            load_store_type,
    output logic                  load_unsigned,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    mau_state_t            r_state;
    mau_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_hi;

    logic [1:0]            w_off;
    logic [2:0]            w_size;
    logic                  w_misaligned;
    logic                  w_cross;
    logic                  w_is_rd;
    logic                  w_is_wr;
    logic [ADDR_WIDTH-1:0] w_word_n;
    logic [ADDR_WIDTH-1:0] w_word_n1;
    logic                  w_cap_lo;
    logic                  w_cap_hi;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_load;

    // A simultaneous read and write request is serviced as a read only.
    assign w_is_rd      = req_read;
    assign w_is_wr      = req_write & ~req_read;
    assign w_off        = req_addr[1:0];
    assign w_size       = ls_size(req_ls_type);
    assign w_misaligned = ((req_ls_type == LS_HALF) & w_off[0]) |
                          ((req_ls_type == LS_WORD) & (w_off != 2'b00));
    assign w_cross      = ({1'b0, w_off} + w_size) > 3'd4;
    assign w_word_n     = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_word_n1    = w_word_n + ADDR_WIDTH'(WORD_BYTES);

    lane_align u_lane_align (
        .i_off      (w_off),
        .i_size     (w_size),
        .i_phase_hi (r_state == ST_WR_HI),
        .i_base     ((r_state == ST_WR_HI) ? r_hi : r_lo),
        .i_wdata    (req_wdata),
        .i_hi       (r_hi),
        .i_lo       (r_lo),
        .i_unsigned (req_unsigned),
        .o_merged   (w_merged),
        .o_load     (w_load)
    );

    // State register; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture of the low and high aligned words read during a split access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lo <= '0;
            r_hi <= '0;
        end else begin
            if (w_cap_lo) r_lo <= mem_read_data;
            if (w_cap_hi) r_hi <= mem_read_data;
        end
    end

    // Next state, memory port drive and core response; all quiet during reset.
    always_comb begin
        w_next          = r_state;
        stall           = 1'b0;
        misaligned_err  = 1'b0;
        resp_rdata      = '0;
        mem_addr        = req_addr;
        mem_write_data  = req_wdata;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        load_store_type = req_ls_type;
        load_unsigned   = req_unsigned;
        w_cap_lo        = 1'b0;
        w_cap_hi        = 1'b0;
        if (rstn) begin
            case (r_state)
                IDLE: begin
                    if ((w_is_rd | w_is_wr) & w_misaligned) begin
`ifdef MISALIGNED_TRAP_EN
                        misaligned_err = 1'b1;
`else
                        mem_addr        = w_word_n;
                        mem_read        = 1'b1;
                        load_store_type = LS_WORD;
                        stall           = 1'b1;
                        w_cap_lo        = 1'b1;
                        if (w_is_rd) begin
                            w_next = w_cross ? LD_HI : DONE;
                        end else begin
                            w_next = ST_WR_LO;
                        end
`endif
                    end else begin
                        mem_read   = w_is_rd;
                        mem_write  = w_is_wr;
                        resp_rdata = mem_read_data;
                    end
                end
                LD_HI: begin
                    mem_addr        = w_word_n1;
                    mem_read        = 1'b1;
                    load_store_type = LS_WORD;
                    stall           = 1'b1;
                    w_cap_hi        = 1'b1;
                    w_next          = DONE;
                end
                ST_WR_LO: begin
                    mem_addr        = w_word_n;
                    mem_write       = 1'b1;
                    mem_write_data  = w_merged;
                    load_store_type = LS_WORD;
                    stall           = 1'b1;
                    w_next          = w_cross ? ST_RD_HI : DONE;
                end
                ST_RD_HI: begin
                    mem_addr        = w_word_n1;
                    mem_read        = 1'b1;
                    load_store_type = LS_WORD;
                    stall           = 1'b1;
                    w_cap_hi        = 1'b1;
                    w_next          = ST_WR_HI;
                end
                ST_WR_HI: begin
                    mem_addr        = w_word_n1;
                    mem_write       = 1'b1;
                    mem_write_data  = w_merged;
                    load_store_type = LS_WORD;
                    stall           = 1'b1;
                    w_next          = DONE;
                end
                DONE: begin
                    resp_rdata = w_load;
                    w_next     = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_misaligned_access_unit.sv
// Directed bench for misaligned_access_unit. A behavioural data_memory sits
// on the memory port; a byte-array reference model predicts load results,
// memory contents and stall counts from the access rules.
module tb_misaligned_access_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_read, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_ls_type;
    logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
    logic        stall, misaligned_err, mem_read, mem_write, load_unsigned;
    logic [1:0]  load_store_type;

    int n_checks = 0;
    int n_errors = 0;

    misaligned_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ls_type(req_ls_type), .req_unsigned(req_unsigned),
        .resp_rdata(resp_rdata), .stall(stall), .misaligned_err(misaligned_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .load_store_type(load_store_type), .load_unsigned(load_unsigned),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural data_memory ----------------
    logic [31:0] mem_w [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always_comb begin
        logic [31:0] sh;
        sh = mem_w[mem_addr[7:2]] >> (8 * mem_addr[1:0]);
        case (load_store_type)
            2'b00:   mem_read_data = {{24{~load_unsigned & sh[7]}}, sh[7:0]};
            2'b01:   mem_read_data = {{16{~load_unsigned & sh[15]}}, sh[15:0]};
            default: mem_read_data = mem_w[mem_addr[7:2]];
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            case (load_store_type)
                2'b00:   mem_w[mem_addr[7:2]][8*mem_addr[1:0] +: 8]       <= mem_write_data[7:0];
                2'b01:   mem_w[mem_addr[7:2]][16*mem_addr[1] +: 16]       <= mem_write_data[15:0];
                default: mem_w[mem_addr[7:2]]                             <= mem_write_data;
            endcase
        end else if (pl_en) begin
            mem_w[pl_idx] <= pl_val;
        end
    end

    // Log of write addresses seen on the memory port during one access.
    logic [31:0] wlog [$];
    always @(negedge clk) begin
        if (mem_write) wlog.push_back(mem_addr);
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:255];

    function automatic int nbytes(input logic [1:0] t);
        return (t == 2'b10) ? 4 : (t == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] t, input logic uns);
        logic [31:0] v;
        int n;
        n = nbytes(t);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
        if (!uns && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic int model_stall(input logic [31:0] a, input logic [1:0] t, input logic rd);
        int off, n;
        off = int'(a[1:0]);
        n   = nbytes(t);
        if ((off % n) == 0) return 0;
        if (rd) return (off + n > 4) ? 2 : 1;
        return (off + n > 4) ? 4 : 2;
    endfunction

    function automatic logic [31:0] model_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        for (int i = 0; i < nbytes(t); i++) ref_mem[8'(a + 32'(i))] = d[8*i +: 8];
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        pl_en  = 1'b1;
        pl_idx = 6'(idx);
        pl_val = v;
        for (int i = 0; i < 4; i++) ref_mem[4*idx+i] = v[8*i +: 8];
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One core access: counts stall cycles, compares the response on the
    // first non-stalled cycle, then applies the store to the model.
    task automatic access(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] t, input logic uns);
        logic [31:0] exp_r;
        int          exp_s, stalls;
        logic        done;
        exp_r = model_load(a, t, uns);
        exp_s = model_stall(a, t, rd);
        wlog.delete();
        req_read = rd; req_write = wr; req_addr = a; req_wdata = d;
        req_ls_type = t; req_unsigned = uns;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                if (rd) chk({nm, "/rdata"}, resp_rdata, exp_r);
                chk({nm, "/err"}, 32'(misaligned_err), 32'd0);
            end else begin
                stalls++;
                @(posedge clk); #1;
            end
        end
        chk({nm, "/completed"}, 32'(done), 32'd1);
        chk({nm, "/stalls"}, 32'(stalls), 32'(exp_s));
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0;
        if (wr && !rd) model_store(a, d, t);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        rstn = 1'b0;
        req_read = 1'b1; req_write = 1'b0; req_addr = 32'h1E; req_wdata = '0;
        req_ls_type = 2'b10; req_unsigned = 1'b0;
        for (int i = 0; i < 10; i++) preload(i, 32'h0);
        #1;
        chk("reset/stall", 32'(stall), 32'd0);
        chk("reset/mem_read", 32'(mem_read), 32'd0);
        chk("reset/mem_write", 32'(mem_write), 32'd0);
        chk("reset/resp_rdata", resp_rdata, 32'd0);
        chk("reset/misaligned_err", 32'(misaligned_err), 32'd0);
        req_read = 1'b0;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Aligned word store then load: no stall, same-cycle data.
        access("st_w_0x14", 1'b0, 1'b1, 32'h14, 32'h12345678, 2'b10, 1'b0);
        chk("st_w_0x14/word5", mem_w[5], model_word(5));
        chk("st_w_0x14/word5_lit", mem_w[5], 32'h12345678);
        access("ld_w_0x14", 1'b1, 1'b0, 32'h14, 32'h0, 2'b10, 1'b0);
        access("ld_b_0x16", 1'b1, 1'b0, 32'h16, 32'h0, 2'b00, 1'b0);
        access("ld_h_0x16", 1'b1, 1'b0, 32'h16, 32'h0, 2'b01, 1'b1);

        preload(7, 32'h11223344);
        preload(8, 32'h55667788);
        chk("model/ld_w_0x1E", model_load(32'h1E, 2'b10, 1'b0), 32'h77881122);
        chk("model/ld_h_0x1F_s", model_load(32'h1F, 2'b01, 1'b0), 32'hFFFF8811);
        chk("model/ld_h_0x1F_u", model_load(32'h1F, 2'b01, 1'b1), 32'h00008811);

`ifdef MISALIGNED_TRAP_EN
        req_read = 1'b1; req_write = 1'b0; req_addr = 32'h1E; req_ls_type = 2'b10;
        @(negedge clk);
        chk("trap_ld/err", 32'(misaligned_err), 32'd1);
        chk("trap_ld/mem_read", 32'(mem_read), 32'd0);
        chk("trap_ld/stall", 32'(stall), 32'd0);
        chk("trap_ld/rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b1; req_addr = 32'h1D; req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        chk("trap_st/err", 32'(misaligned_err), 32'd1);
        chk("trap_st/mem_write", 32'(mem_write), 32'd0);
        chk("trap_st/stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        req_write = 1'b0;
        chk("trap_st/word7", mem_w[7], 32'h11223344);
        access("trap_after_ld", 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
`else
        access("ld_w_0x1E", 1'b1, 1'b0, 32'h1E, 32'h0, 2'b10, 1'b0);
        access("ld_h_0x1F_s", 1'b1, 1'b0, 32'h1F, 32'h0, 2'b01, 1'b0);
        access("ld_h_0x1F_u", 1'b1, 1'b0, 32'h1F, 32'h0, 2'b01, 1'b1);

        access("st_w_0x1D", 1'b0, 1'b1, 32'h1D, 32'hAABBCCDD, 2'b10, 1'b0);
        chk("st_w_0x1D/nwrites", 32'(wlog.size()), 32'd2);
        chk("st_w_0x1D/wr0_addr", wlog.size() > 0 ? wlog[0] : 32'hFFFF_FFFF, 32'h1C);
        chk("st_w_0x1D/wr1_addr", wlog.size() > 1 ? wlog[1] : 32'hFFFF_FFFF, 32'h20);
        chk("st_w_0x1D/word7", mem_w[7], model_word(7));
        chk("st_w_0x1D/word8", mem_w[8], model_word(8));
        chk("st_w_0x1D/word7_lit", mem_w[7], 32'hBBCCDD44);
        chk("st_w_0x1D/word8_lit", mem_w[8], 32'h556677AA);

        access("ld_h_0x1D", 1'b1, 1'b0, 32'h1D, 32'h0, 2'b01, 1'b0);

        preload(5, 32'h0);
        preload(6, 32'hA5A5A5A5);
        access("st_h_0x15", 1'b0, 1'b1, 32'h15, 32'h0000BEEF, 2'b01, 1'b0);
        chk("st_h_0x15/nwrites", 32'(wlog.size()), 32'd1);
        chk("st_h_0x15/wr0_addr", wlog.size() > 0 ? wlog[0] : 32'hFFFF_FFFF, 32'h14);
        chk("st_h_0x15/word5", mem_w[5], 32'h00BEEF00);
        chk("st_h_0x15/word6", mem_w[6], model_word(6));

        access("rdwr_0x1E", 1'b1, 1'b1, 32'h1E, 32'hDEADBEEF, 2'b10, 1'b0);
        chk("rdwr_0x1E/nwrites", 32'(wlog.size()), 32'd0);
        chk("rdwr_0x1E/word8", mem_w[8], model_word(8));

        access("st_b_0x1B", 1'b0, 1'b1, 32'h1B, 32'h00000080, 2'b00, 1'b0);
        access("ld_b_0x1B_s", 1'b1, 1'b0, 32'h1B, 32'h0, 2'b00, 1'b0);

        // Reset while the high word of a crossing store is being read.
        preload(7, 32'h11223344);
        preload(8, 32'h55667788);
        req_read = 1'b0; req_write = 1'b1; req_addr = 32'h1D; req_wdata = 32'hCAFEF00D;
        req_ls_type = 2'b10; req_unsigned = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid/in_rd_hi", 32'({stall, mem_read, mem_write}), 32'b110);
        rstn = 1'b0;
        #1;
        chk("rst_mid/stall", 32'(stall), 32'd0);
        chk("rst_mid/mem_read", 32'(mem_read), 32'd0);
        chk("rst_mid/mem_write", 32'(mem_write), 32'd0);
        chk("rst_mid/resp_rdata", resp_rdata, 32'd0);
        req_write = 1'b0;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        ref_mem[8'h1D] = 8'h0D; ref_mem[8'h1E] = 8'hF0; ref_mem[8'h1F] = 8'hFE;
        chk("rst_mid/word7_partial", mem_w[7], 32'hFEF00D44);
        chk("rst_mid/word8_lit", mem_w[8], 32'h55667788);
        access("rst_mid/ld_0x20", 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        access("rst_mid/ld_0x1C", 1'b1, 1'b0, 32'h1C, 32'h0, 2'b10, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/misaligned_access_unit.md
Name: misaligned_access_unit

Overview:
- Sits directly upstream of data_memory, between the core's load/store datapath and the memory port.
- Aligned accesses pass straight through in one cycle.
- Misaligned halfword/word accesses are split into aligned word reads and read-modify-write sequences, with a stall to the single-cycle core.
- Loads are reassembled, then sign- or zero-extended, before they return to the core.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; lane logic supports only 32

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
req_read  in  1  core load request (held stable while stall=1)
req_write  in  1  core store request (held stable while stall=1)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data
req_ls_type  in  2  LS_BYTE/LS_HALF/LS_WORD from controls.sv
req_unsigned  in  1  zero-extend load
resp_rdata  out  DATA_WIDTH  load result; valid when stall=0
stall  out  1  core must hold PC and request
misaligned_err  out  1  trap flag (see Optional Feature)
mem_addr  out  ADDR_WIDTH  to data_memory
mem_write_data  out  DATA_WIDTH  to data_memory
mem_read  out  1  to data_memory
mem_write  out  1  to data_memory
load_store_type  out  2  to data_memory
load_unsigned  out  1  to data_memory
mem_read_data  in  DATA_WIDTH  combinational read data from data_memory

Behaviour:
- Interface: one clock `clk`; `rstn` is asynchronous, active-low.
- While rstn=0:
  - state=IDLE; capture registers are 0.
  - stall, mem_read, mem_write, resp_rdata and misaligned_err are all forced to 0.
- Definitions:
  - off=req_addr[1:0]; size = 1, 2 or 4 bytes.
  - misaligned = (HALF & off[0]) | (WORD & off!=0).
  - cross = off+size>4.
  - wordN = {req_addr[ADDR_WIDTH-1:2], 2'b00}; wordN1 = wordN+4, wrapping modulo 2^ADDR_WIDTH.
- IDLE, aligned access or BYTE:
  - Drive the request through unchanged; resp_rdata = mem_read_data; stall=0.
  - Latency is 0 extra cycles.
  - A store commits at the clk edge.
- IDLE, misaligned access:
  - Issue a WORD read at wordN, capture it in lo_q, stall=1.
  - Next state: loads go to LD_HI if cross, else DONE; stores go to ST_WR_LO.
- LD_HI: WORD read at wordN1, capture hi_q, stall=1 -> DONE.
- ST_WR_LO:
  - WORD write at wordN of lo_q merged with the store bytes that fall in lanes off..3; stall=1.
  - Next: ST_RD_HI if cross, else DONE.
- ST_RD_HI: WORD read at wordN1 into hi_q, stall=1 -> ST_WR_HI.
- ST_WR_HI: WORD write at wordN1 of hi_q merged with the remaining store bytes in lanes 0..(off+size-5); stall=1 -> DONE.
- DONE:
  - No memory access; stall=0.
  - resp_rdata = bytes extracted little-endian from {hi_q,lo_q} starting at off, extended per req_unsigned.
  - Next state: IDLE.
- Cycle counts:
  - Load: 2 cycles non-crossing, 3 crossing.
  - Store: 3 cycles non-crossing, 5 crossing.
- req_read and req_write both high: treated as read; writes are never issued.
- Reset asserted mid-sequence: return to IDLE immediately. A partial RMW may leave the first word written; this is not rolled back.

Optional Feature:
MISALIGNED_TRAP_EN:
- Defined:
  - A misaligned request never touches memory (mem_read=mem_write=0).
  - misaligned_err=1 and stall=0 for that cycle; resp_rdata=0.
  - The FSM stays in IDLE.
- Undefined: splitting operates as above and misaligned_err is tied to 0.

Decomposition:
- mem_access_pkg holds:
  - the state enum (IDLE, LD_HI, ST_WR_LO, ST_RD_HI, ST_WR_HI, DONE);
  - a ls_size function mapping LS_* to 1/2/4;
  - a WORD_BYTES=4 constant.
- LS_* encodings remain in controls.sv.
- One sub-module, lane_align (purely combinational), provides:
  - store-byte merge into a word given off/size/phase;
  - load extract and sign/zero-extend from a 64-bit {hi,lo}.

Test Plan:
- Aligned LS_WORD store 0x12345678 at 0x14, then load -> stall never asserts; resp_rdata=0x12345678 in the same cycle.
- Preload word7=0x11223344, word8=0x55667788; LS_WORD load at 0x1E -> stall high 2 cycles, then resp_rdata=0x77881122.
- Same preload; LS_HALF load at 0x1F with req_unsigned=0 -> 0xFFFF8811; with req_unsigned=1 -> 0x00008811.
- Same preload; LS_WORD store 0xAABBCCDD at 0x1D -> stall high 4 cycles; word7=0xBBCCDD44, word8=0x556677AA.
- LS_HALF store 0xBEEF at 0x15 with word5=0 -> 2 stall cycles, no second word touched; word5=0x00BEEF00.
- Assert rstn=0 during ST_RD_HI of a crossing store -> outputs 0 at once; after release, state is IDLE; word8 is unchanged. With MISALIGNED_TRAP_EN, a load at 0x1E gives misaligned_err=1, mem_read=0 and stall=0.
